// File: rtl/pm_run_monitor.sv
// pm_run_monitor: detects end-of-run (exception, PC self-loop, cycle budget),
// freezes the machine and streams the whole register file out over valid/ready.
`default_nettype none

module pm_run_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_CYCLES = 30,
  parameter int LOOP_LIMIT = 4,
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  except,
  output logic                  halt,
  output logic [IDX_W-1:0]      rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [IDX_W-1:0]      dump_idx,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  done,
  output logic [1:0]            cause,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_DUMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int LCW = (LOOP_LIMIT > 1) ? $clog2(LOOP_LIMIT + 1) : 1;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic [LCW-1:0]        r_loop;
  logic [LCW-1:0]        w_loop_inc;
  logic [ADDR_WIDTH-1:0] r_prev_pc;
  logic                  r_pc_seen;
  logic [IDX_W-1:0]      r_idx;
  logic [1:0]            r_cause;
  logic [1:0]            w_cause_hit;
  logic                  w_pc_eq;
  logic                  w_hit_loop;
  logic                  w_hit_tmo;
  logic                  w_term;
  logic                  w_last_beat;

  // Termination detection for the current RUN edge; priority exception > loop > timeout.
  always_comb begin
    w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    w_pc_eq     = r_pc_seen && (pc == r_prev_pc);
    w_loop_inc  = !w_pc_eq ? '0 : ((r_loop == '1) ? r_loop : r_loop + 1'b1);
    w_hit_loop  = (LOOP_LIMIT != 0) && w_pc_eq && (w_loop_inc == LCW'(LOOP_LIMIT));
    w_hit_tmo   = (MAX_CYCLES != 0) && (w_cnt_inc == CNT_WIDTH'(MAX_CYCLES));
    w_term      = except || w_hit_loop || w_hit_tmo;
    w_last_beat = (r_idx == IDX_W'(NUM_REGS - 1));
    if (except)          w_cause_hit = 2'b10;
    else if (w_hit_loop) w_cause_hit = 2'b11;
    else if (w_hit_tmo)  w_cause_hit = 2'b01;
    else                 w_cause_hit = 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_term) w_state_nxt = S_DUMP;
      S_DUMP:  if (dump_ready && w_last_beat) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_loop    <= '0;
      r_prev_pc <= '0;
      r_pc_seen <= 1'b0;
      r_idx     <= '0;
      r_cause   <= 2'b00;
    end else if (r_state == S_RUN) begin
      r_cnt     <= w_cnt_inc;
      r_loop    <= w_loop_inc;
      r_prev_pc <= pc;
      r_pc_seen <= 1'b1;
      if (w_term) begin
        r_cause <= w_cause_hit;
        r_idx   <= '0;
      end
    end else if (r_state == S_DUMP) begin
      // Index parks on the last entry; it is not observed once DONE.
      if (dump_ready && !w_last_beat) r_idx <= r_idx + 1'b1;
    end
  end

  always_comb begin
    halt        = (r_state != S_RUN);
    dump_valid  = (r_state == S_DUMP);
    done        = (r_state == S_DONE);
    rf_raddr    = r_idx;
    dump_idx    = r_idx;
    dump_data   = rf_rdata;
    cause       = r_cause;
    cycle_count = r_cnt;
  end

endmodule

`default_nettype wire

// File: tb/tb_pm_run_monitor.sv
// Directed, table-driven bench for pm_run_monitor with a 3*i register-file model.
`default_nettype none

module tb_pm_run_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic        except = 1'b0;
  logic        halt;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        done;
  logic [1:0]  cause;
  logic [15:0] cycle_count;

  logic        f_reset = 1'b0;
  logic [31:0] f_pc = 32'h1234;
  logic        f_halt, f_valid, f_done;
  logic [4:0]  f_raddr, f_idx;
  logic [31:0] f_data;
  logic [1:0]  f_cause;
  logic [7:0]  f_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign rf_rdata = 32'(rf_raddr) * 32'd3;

  pm_run_monitor u_dut (
    .clk(clk), .reset(reset), .pc(pc), .except(except), .halt(halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .done(done), .cause(cause), .cycle_count(cycle_count)
  );

  // Free-running variant: no timeout, no loop detection, narrow saturating counter.
  pm_run_monitor #(.CNT_WIDTH(8), .MAX_CYCLES(0), .LOOP_LIMIT(0)) u_free (
    .clk(clk), .reset(f_reset), .pc(f_pc), .except(1'b0), .halt(f_halt),
    .rf_raddr(f_raddr), .rf_rdata(32'hDEAD_BEEF), .dump_valid(f_valid),
    .dump_ready(1'b1), .dump_idx(f_idx), .dump_data(f_data),
    .done(f_done), .cause(f_cause), .cycle_count(f_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic        exc;
    logic        halt;
    logic [1:0]  cause;
    logic [15:0] cnt;
    logic        valid;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pc = '0;
    except = 1'b0;
    dump_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int exp_idx;
    int cyc;
    logic rdy;

    vecs[0] = '{32'h00, 1'b0, 1'b0, 2'b00, 16'd1, 1'b0};
    vecs[1] = '{32'h04, 1'b0, 1'b0, 2'b00, 16'd2, 1'b0};
    vecs[2] = '{32'h08, 1'b0, 1'b0, 2'b00, 16'd3, 1'b0};
    vecs[3] = '{32'h0C, 1'b0, 1'b0, 2'b00, 16'd4, 1'b0};
    vecs[4] = '{32'h10, 1'b0, 1'b0, 2'b00, 16'd5, 1'b0};
    vecs[5] = '{32'h14, 1'b0, 1'b0, 2'b00, 16'd6, 1'b0};
    vecs[6] = '{32'h18, 1'b1, 1'b1, 2'b10, 16'd7, 1'b1};
    vecs[7] = '{32'h1C, 1'b1, 1'b1, 2'b10, 16'd7, 1'b1};

    // Reset state
    #3;
    check("reset_outputs", {halt, dump_valid, done, cause, cycle_count, dump_idx},
          {1'b0, 1'b0, 1'b0, 2'b00, 16'd0, 5'd0});
    do_reset();

    // Exception on the 7th RUN edge; the 8th row shows inputs ignored once halted.
    for (int i = 0; i < 8; i++) begin
      pc = vecs[i].pc;
      except = vecs[i].exc;
      tick();
      check($sformatf("exc_vec%0d", i), {halt, cause, cycle_count, dump_valid},
            {vecs[i].halt, vecs[i].cause, vecs[i].cnt, vecs[i].valid});
    end
    except = 1'b0;
    check("dump_first_idx", dump_idx, 5'd0);

    // Dump with ready toggling 1,0,1,0...
    exp_idx = 0;
    cyc = 0;
    rdy = 1'b1;
    while (!done && cyc < 200) begin
      check("dump_valid", dump_valid, 1'b1);
      check("dump_idx", dump_idx, exp_idx);
      check("dump_data", dump_data, 3 * exp_idx);
      dump_ready = rdy;
      tick();
      cyc++;
      if (rdy) exp_idx++;
      rdy = !rdy;
    end
    check("dump_cycles", cyc, 63);
    check("dump_beats", exp_idx, 32);
    check("done_state", {done, dump_valid, halt, cause, cycle_count},
          {1'b1, 1'b0, 1'b1, 2'b10, 16'd7});
    dump_ready = 1'b0;
    except = 1'b1;
    pc = 32'h500;
    repeat (3) tick();
    except = 1'b0;
    check("done_sticky", {done, dump_valid, halt, cause, cycle_count},
          {1'b1, 1'b0, 1'b1, 2'b10, 16'd7});

    // Self-loop: 0x00..0x1C then hold 0x20 -> halt on 5th edge at 0x20.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pc = 32'(4 * i);
      tick();
    end
    pc = 32'h20;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("loop_wait%0d", k), halt, 1'b0);
    end
    tick();
    check("loop_halt", {halt, cause, cycle_count}, {1'b1, 2'b11, 16'd13});

    // First edge after reset must not count as an equal-PC comparison.
    do_reset();
    pc = 32'h0;
    repeat (4) tick();
    check("loop_first_edge", halt, 1'b0);
    tick();
    check("loop_from_reset", {halt, cause, cycle_count}, {1'b1, 2'b11, 16'd5});

    // Timeout at 30 edges.
    do_reset();
    for (int i = 1; i <= 29; i++) begin
      pc = 32'(8 * i);
      tick();
    end
    check("tmo_wait", {halt, cycle_count}, {1'b0, 16'd29});
    pc = 32'h1000;
    tick();
    check("tmo_halt", {halt, cause, cycle_count}, {1'b1, 2'b01, 16'd30});

    // Exception coincides with 4th equal comparison -> exception wins.
    do_reset();
    pc = 32'h40;
    repeat (4) tick();
    check("prio_wait", halt, 1'b0);
    except = 1'b1;
    tick();
    except = 1'b0;
    check("prio_cause", {halt, cause, cycle_count}, {1'b1, 2'b10, 16'd5});

    // Reset abort in the middle of a dump.
    do_reset();
    except = 1'b1;
    tick();
    except = 1'b0;
    check("abort_trigger", {halt, cause, cycle_count}, {1'b1, 2'b10, 16'd1});
    dump_ready = 1'b1;
    repeat (10) tick();
    check("abort_mid", {dump_valid, dump_idx, dump_data}, {1'b1, 5'd10, 32'd30});
    #2;
    reset = 1'b0;
    #1;
    check("abort_async", {halt, dump_valid, done, cause, cycle_count, dump_idx},
          {1'b0, 1'b0, 1'b0, 2'b00, 16'd0, 5'd0});
    tick();
    tick();
    check("abort_held", {halt, dump_valid, done, cause, cycle_count, dump_idx},
          {1'b0, 1'b0, 1'b0, 2'b00, 16'd0, 5'd0});
    reset = 1'b1;
    dump_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      pc = 32'(4 * i);
      tick();
    end
    check("abort_restart", {halt, cycle_count}, {1'b0, 16'd3});
    pc = 32'h10;
    except = 1'b1;
    tick();
    except = 1'b0;
    check("abort_redump", {halt, cause, cycle_count, dump_valid, dump_idx, dump_data},
          {1'b1, 2'b10, 16'd4, 1'b1, 5'd0, 32'd0});

    // Free-running instance: no halt, 8-bit counter saturates.
    f_reset = 1'b1;
    repeat (255) tick();
    check("free_at_max", {f_halt, f_cnt}, {1'b0, 8'hFF});
    repeat (1745) tick();
    check("free_2000", {f_halt, f_valid, f_done, f_cause, f_cnt},
          {1'b0, 1'b0, 1'b0, 2'b00, 8'hFF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
